// File: rtl/apb_uart_tx_slave_pkg.sv
// apb_uart_tx_slave_pkg
// Shared definitions for the APB UART transmitter slave:
//   - register word offsets (PADDR[3:2])
//   - STATUS register bit positions
//   - TX serialiser state encoding
//   - helper that turns the programmed baud divisor into an effective one
`timescale 1ns/1ps
package apb_uart_tx_slave_pkg;

    // Register word offsets, decoded from PADDR[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    // CTRL bit positions
    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // STATUS bit positions; the fill count occupies [ST_CNT_MSB:ST_CNT_LSB]
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 7;

    // Serialiser state encoding
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = TX_IDLE,
        S_START = TX_START,
        S_DATA  = TX_DATA,
        S_STOP  = TX_STOP
    } tx_state_t;

    // A programmed divisor of 0 would stall the bit counter; treat it as 1.
    function automatic logic [15:0] eff_div(input logic [15:0] baud);
        return (baud == 16'd0) ? 16'd1 : baud;
    endfunction

endpackage

// File: rtl/apb_uart_tx_slave_if.sv
// apb_uart_tx_slave_if
// APB3 bus bundle between the wrapper decoder/master and the UART TX slave.
// Handshake: zero-wait-state APB3. A transfer is a setup cycle
// (PSEL=1, PENABLE=0) followed by one access cycle (PSEL=1, PENABLE=1);
// the slave holds PREADY=1, so every access phase completes in one cycle.
// Writes commit at the end of the access cycle, read data is valid during
// the access cycle, PSLVERR is only meaningful during the access cycle.
//   master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB
//   slave  modport: drives PRDATA/PREADY/PSLVERR
`timescale 1ns/1ps
interface apb_uart_tx_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [3:0]            PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_tx_slave_tx_fifo.sv
// apb_uart_tx_slave_tx_fifo
// Small synchronous byte FIFO feeding the UART serialiser.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: push request and byte; ignored when full unless a pop
//                    happens in the same cycle
//   i_pop          : pop request; ignored when empty
//   o_rdata        : byte at the head (valid when !o_empty)
//   o_count        : fill level, $clog2(DEPTH)+1 bits
//   o_full, o_empty: level flags
`timescale 1ns/1ps
module apb_uart_tx_slave_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_pop_ok  = i_pop & (r_count != '0);
    assign w_push_ok = i_push & ((r_count != (AW+1)'(DEPTH)) | w_pop_ok);

    // Storage carries no reset; entries are meaningless once the pointers reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/apb_uart_tx_slave.sv
// apb_uart_tx_slave
// APB3 slave that queues bytes into a TX FIFO and sends them as 8N1 frames.
// Ports:
//   PCLK, PRESET_n : clock, asynchronous active-low reset
//   apb            : APB3 slave modport (PSEL..PSTRB in, PRDATA/PREADY/PSLVERR out)
//   TXD            : serial output, idles high
//   IRQ            : level interrupt, IRQ_EN & FIFO empty & serialiser idle
//   o_dbg_state    : current serialiser state (tx_state_t encoding)
// Registers (PADDR[3:2]): CTRL RW, STATUS RO (+ OVF clear), DATA WO, BAUD RW.
`timescale 1ns/1ps
module apb_uart_tx_slave
    import apb_uart_tx_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET = 16'd10
) (
    input  logic                   PCLK,
    input  logic                   PRESET_n,
    apb_uart_tx_slave_if.slave     apb,
    output logic                   TXD,
    output logic                   IRQ,
    output logic [1:0]             o_dbg_state
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic [1:0] w_addr;
    logic       w_wr;
    logic       w_rd_setup;
    logic       w_push_req;
    logic       w_ovf_hit;

    assign w_addr     = apb.PADDR[3:2];
    assign w_wr       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_rd_setup = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign w_push_req = w_wr & (w_addr == REG_DATA) & apb.PSTRB[0];

    // ---------------- FIFO ----------------
    logic [7:0]    w_fifo_rdata;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    apb_uart_tx_slave_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (PCLK),
        .i_rst_n (PRESET_n),
        .i_push  (w_push_req),
        .i_wdata (apb.PWDATA[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A push is only dropped when full and the serialiser is not popping now.
    assign w_ovf_hit = w_push_req & w_full & ~w_pop;

    // ---------------- register file ----------------
    logic [1:0]            r_ctrl;
    logic [15:0]           r_baud;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_irq;
    tx_state_t             r_state;

    logic [7:0]            w_status;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    always_comb begin
        w_status                        = '0;
        w_status[ST_FULL]               = w_full;
        w_status[ST_EMPTY]              = w_empty;
        w_status[ST_BUSY]               = (r_state != S_IDLE);
        w_status[ST_OVF]                = r_ovf;
        w_status[ST_CNT_MSB:ST_CNT_LSB] = 4'(w_count);
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_addr)
            REG_CTRL:   w_rd_mux[1:0]  = r_ctrl;
            REG_STATUS: w_rd_mux[7:0]  = w_status;
            REG_BAUD:   w_rd_mux[15:0] = r_baud;
            default:    w_rd_mux       = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_ctrl   <= '0;
            r_baud   <= BAUD_RESET;
            r_ovf    <= 1'b0;
            r_prdata <= '0;
        end else begin
            if (w_wr && apb.PSTRB[0] && (w_addr == REG_CTRL)) begin
                r_ctrl <= apb.PWDATA[1:0];
            end
            if (w_wr && (w_addr == REG_BAUD)) begin
                if (apb.PSTRB[0]) r_baud[7:0]  <= apb.PWDATA[7:0];
                if (apb.PSTRB[1]) r_baud[15:8] <= apb.PWDATA[15:8];
            end
            // Setting wins over a simultaneous clear (they cannot coincide on one bus).
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end else if (w_wr && apb.PSTRB[0] && (w_addr == REG_STATUS) && apb.PWDATA[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            // Read data is captured in the setup cycle and held until the next read.
            if (w_rd_setup) begin
                r_prdata <= w_rd_mux;
            end
        end
    end

    assign apb.PRDATA  = r_prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_ovf_hit;

    // ---------------- serialiser FSM ----------------
    tx_state_t   w_next_state;
    logic        w_load;
    logic        w_tick;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic [15:0] w_div;

    assign w_tick = (r_cnt == 16'd0);
    assign w_div  = eff_div(r_baud);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // w_load marks the edge that starts a frame: pop a byte, drive the start bit.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[CTRL_TX_EN] && !w_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_tick) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_ctrl[CTRL_TX_EN] && !w_empty) begin
                        w_pop        = 1'b1;
                        w_load       = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Each bit lasts w_div cycles: counter loads div-1 and the state advances
    // on the cycle it reads 0. The divisor is sampled only at reloads, so a
    // BAUD write mid-bit applies from the next bit.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else if (w_load) begin
            r_shift <= w_fifo_rdata;
            r_txd   <= 1'b0;
            r_cnt   <= w_div - 16'd1;
        end else if (r_state != S_IDLE) begin
            if (w_tick) begin
                r_cnt <= w_div - 16'd1;
                case (r_state)
                    S_START: begin
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= 3'd0;
                    end
                    S_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_txd <= 1'b1;
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    default: r_txd <= 1'b1;
                endcase
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl[CTRL_IRQ_EN] & w_empty & (r_state == S_IDLE);
        end
    end

    assign TXD         = r_txd;
    assign IRQ         = r_irq;
    assign o_dbg_state = r_state;

    // Address and data bits outside the decoded fields.
    logic w_unused;
    assign w_unused = &{1'b0, apb.PADDR[ADDR_WIDTH-1:4], apb.PADDR[1:0],
                        apb.PWDATA[DATA_WIDTH-1:16], apb.PSTRB[3:2]};

endmodule

// File: tb/tb_apb_uart_tx_slave.sv
// tb_apb_uart_tx_slave
// Directed bench for apb_uart_tx_slave: a register-access vector table plus
// hand-written sequences for frame timing, FIFO overflow, IRQ and reset.
`timescale 1ns/1ps
module tb_apb_uart_tx_slave;
    import apb_uart_tx_slave_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_uart_tx_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_bus ();
    logic       txd;
    logic       irq;
    logic [1:0] dbg_state;

    apb_uart_tx_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .BAUD_RESET(16'd10)
    ) dut (
        .PCLK        (clk),
        .PRESET_n    (rst_n),
        .apb         (apb_bus.slave),
        .TXD         (txd),
        .IRQ         (irq),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic err);
        @(negedge clk);
        apb_bus.PSEL    = 1'b1;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b1;
        apb_bus.PADDR   = {28'd0, addr};
        apb_bus.PWDATA  = data;
        apb_bus.PSTRB   = strb;
        @(negedge clk);
        apb_bus.PENABLE = 1'b1;
        #1 err = apb_bus.PSLVERR;
        @(negedge clk);
        apb_bus.PSEL    = 1'b0;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        apb_bus.PSEL    = 1'b1;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b0;
        apb_bus.PADDR   = {28'd0, addr};
        apb_bus.PSTRB   = 4'h0;
        @(negedge clk);
        apb_bus.PENABLE = 1'b1;
        #1 data = apb_bus.PRDATA;
        @(negedge clk);
        apb_bus.PSEL    = 1'b0;
        apb_bus.PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic e;
        apb_write(addr, data, 4'hF, e);
        check($sformatf("wr_err_%0h", addr), {31'd0, e}, 32'd0);
    endtask

    task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        check(name, d, exp);
    endtask

    // Consumes n frames from exp_q, checking TXD every cycle of each bit.
    task automatic check_frames(input int n, input int div);
        logic [7:0] b;
        logic       bit_v;
        for (int f = 0; f < n; f++) begin
            b = exp_q.pop_front();
            for (int k = 0; k < 10; k++) begin
                if (k == 0)      bit_v = 1'b0;
                else if (k == 9) bit_v = 1'b1;
                else             bit_v = b[k-1];
                for (int c = 0; c < div; c++) begin
                    @(negedge clk);
                    check($sformatf("txd_f%0d_b%0d_c%0d", f, k, c), {31'd0, txd}, {31'd0, bit_v});
                end
            end
        end
    endtask

    // ---------------- register vector table ----------------
    typedef struct {
        bit          is_write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic        e;
        logic [31:0] d;

        apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
        apb_bus.PADDR = '0;  apb_bus.PWDATA = '0;    apb_bus.PSTRB = '0;

        vecs[0]  = '{0, 4'h4, 32'h0,       4'h0, 32'h0000_0002, 1'b0}; // STATUS: EMPTY
        vecs[1]  = '{0, 4'hC, 32'h0,       4'h0, 32'h0000_000A, 1'b0}; // BAUD reset
        vecs[2]  = '{0, 4'h0, 32'h0,       4'h0, 32'h0000_0000, 1'b0}; // CTRL reset
        vecs[3]  = '{0, 4'h8, 32'h0,       4'h0, 32'h0000_0000, 1'b0}; // DATA reads 0
        vecs[4]  = '{1, 4'h0, 32'h3,       4'h0, 32'h0,         1'b0}; // CTRL, no strobes
        vecs[5]  = '{0, 4'h0, 32'h0,       4'h0, 32'h0000_0000, 1'b0}; // CTRL unchanged
        vecs[6]  = '{1, 4'hC, 32'h0001_2345, 4'h1, 32'h0,       1'b0}; // BAUD low lane only
        vecs[7]  = '{0, 4'hC, 32'h0,       4'h0, 32'h0000_0045, 1'b0};
        vecs[8]  = '{1, 4'hC, 32'h0000_FFFF, 4'h2, 32'h0,       1'b0}; // BAUD high lane only
        vecs[9]  = '{0, 4'hC, 32'h0,       4'hF, 32'h0000_FF45, 1'b0}; // strobes ignored on read
        vecs[10] = '{1, 4'h4, 32'h0000_00F7, 4'hF, 32'h0,       1'b0}; // STATUS not writable
        vecs[11] = '{0, 4'h4, 32'h0,       4'h0, 32'h0000_0002, 1'b0};

        // reset
        repeat (3) @(negedge clk);
        check("rst_txd",    {31'd0, txd}, 32'd1);
        check("rst_irq",    {31'd0, irq}, 32'd0);
        check("rst_prdata", apb_bus.PRDATA, 32'd0);
        check("rst_pready", {31'd0, apb_bus.PREADY}, 32'd1);
        check("rst_pslverr", {31'd0, apb_bus.PSLVERR}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", {30'd0, dbg_state}, {30'd0, TX_IDLE});

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write) begin
                apb_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, e);
                check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            end else begin
                apb_read(vecs[i].addr, d);
                check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rdata);
            end
        end

        // ---- single frame 0xA5 at divisor 4, STATUS read mid-frame ----
        wr(4'hC, 32'd4);
        wr(4'h0, 32'd1);
        exp_q.push_back(8'hA5);
        wr(4'h8, 32'h0000_00A5);
        fork
            check_frames(1, 4);
            begin
                repeat (10) @(negedge clk);
                rd_check("busy_status", 4'h4, 32'h0000_0006);
            end
        join

        // ---- overflow with TX disabled, then four back-to-back frames ----
        wr(4'h0, 32'd0);
        wr(4'hC, 32'd2);
        for (int i = 0; i < 5; i++) begin
            apb_write(4'h8, 32'h11 + i, 4'hF, e);
            check($sformatf("ovf_wr%0d_pslverr", i), {31'd0, e}, (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) exp_q.push_back(8'(8'h11 + i));
        end
        rd_check("full_status", 4'h4, 32'h0000_0049);
        wr(4'h0, 32'd1);
        check_frames(4, 2);
        wr(4'h4, 32'h0000_0008);
        rd_check("ovf_cleared", 4'h4, 32'h0000_0002);

        // ---- IRQ around a single frame at divisor 3 ----
        wr(4'hC, 32'd3);
        wr(4'h0, 32'd3);
        @(negedge clk);
        check("irq_idle_empty", {31'd0, irq}, 32'd1);
        exp_q.push_back(8'h3C);
        wr(4'h8, 32'h0000_003C);
        fork
            check_frames(1, 3);
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                check($sformatf("irq_busy_c%0d", c), {31'd0, irq}, 32'd0);
            end
        join
        @(negedge clk);
        check("irq_stop_to_idle", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_after_idle", {31'd0, irq}, 32'd1);

        // ---- reset during data bit 3 ----
        wr(4'h0, 32'd0);
        wr(4'hC, 32'd4);
        wr(4'h0, 32'd1);
        wr(4'h8, 32'h0000_0000);
        repeat (18) @(negedge clk);
        check("bit3_txd_low", {31'd0, txd}, 32'd0);
        check("bit3_state",   {30'd0, dbg_state}, {30'd0, TX_DATA});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_txd",   {31'd0, txd}, 32'd1);
        check("async_rst_state", {30'd0, dbg_state}, {30'd0, TX_IDLE});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_check("rst_status", 4'h4, 32'h0000_0002);
        rd_check("rst_ctrl",   4'h0, 32'h0000_0000);
        rd_check("rst_baud",   4'hC, 32'h0000_000A);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check($sformatf("no_resume_c%0d", c), {31'd0, txd}, 32'd1);
        end

        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net; the sequence above is fixed-length and ends far earlier.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_uart_tx_slave.md
Name: apb_uart_tx_slave

Overview:
- APB3 slave for the APB wrapper's address decoder; sits beside the MEM and timer slaves, downstream of the APB master.
- Takes bytes from the bus into a small TX FIFO and serialises them as 8N1 frames on TXD, using a programmable baud divisor.
- Exposes control, status, data and baud registers, plus a level interrupt.

Parameters:
- ADDR_WIDTH, 32, width of PADDR; only PADDR[3:2] is decoded.
- DATA_WIDTH, 32, width of PWDATA and PRDATA.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2.
- BAUD_RESET, 16'd10, reset value of the baud divisor.

Ports:
- PCLK  in  1  clock; all logic samples on the rising edge.
- PRESET_n  in  1  reset; asynchronous assertion, active-low.
- PSEL  in  1  slave select from the wrapper decoder.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  4  byte-lane strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- TXD  out  1  serial output; idles high.
- IRQ  out  1  interrupt, active-high level.

Behaviour:
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0, TXD=1, IRQ=0, CTRL=0, BAUD=BAUD_RESET, FIFO empty, OVF=0, FSM=IDLE.
- Register map (word offset PADDR[3:2]), strobes apply per byte lane:
  - 0x0 CTRL, RW: bit0 TX_EN, bit1 IRQ_EN.
  - 0x4 STATUS, read: bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVF, bits[7:4] fill count. Writing 1 to bit3 with PSTRB[0]=1 clears OVF.
  - 0x8 DATA, write-only: pushes PWDATA[7:0] when PSTRB[0]=1; reads return 0.
  - 0xC BAUD, RW: bits[15:0] = cycles per bit; a value of 0 behaves as 1.
- APB timing:
  - Zero wait states; PREADY is always 1.
  - Writes commit on the edge where PSEL & PENABLE & PWRITE.
  - PRDATA is registered on the setup edge (PSEL & !PENABLE & !PWRITE), is valid throughout the access phase, and holds until the next read.
  - PSTRB is ignored for reads.
  - PSLVERR=1 only during an access-phase DATA write while FULL; in that case the byte is dropped and OVF is set.
- FIFO:
  - Push and pop may happen in the same cycle. If full, the pop frees a slot, the push is accepted, and no OVF is raised.
  - Pointers wrap modulo FIFO_DEPTH. The count is (log2 FIFO_DEPTH)+1 bits wide.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on the edge where TX_EN & !EMPTY. On that edge the FIFO pops into the shift register, TXD←0, and the baud counter←divisor−1.
  - Each bit holds for exactly divisor cycles. When the counter hits 0 the FSM advances and the counter reloads.
  - START→DATA. DATA shifts out 8 bits LSB first, with a 3-bit bit index.
  - DATA→STOP after bit 7. STOP drives TXD=1 for one bit period.
  - STOP→START back-to-back if TX_EN & !EMPTY, otherwise STOP→IDLE. A full frame is 10×divisor cycles with no idle gap between frames.
  - Clearing TX_EN mid-frame: the current frame completes, then the FSM returns to IDLE.
  - A BAUD write mid-frame takes effect at the next counter reload.
- IRQ is registered: IRQ = IRQ_EN & EMPTY & (FSM==IDLE).
- Reset asserted mid-frame: TXD goes high immediately (asynchronously), the FIFO contents are lost, and all registers return to their reset values.

Decomposition:
- Shared package holds:
  - register offsets CTRL/STATUS/DATA/BAUD;
  - STATUS bit positions;
  - FSM state encoding (2-bit localparams).
- One sub-module, tx_fifo, containing the memory, pointers, count and full/empty flags, with push/pop/data ports.
- The APB register file and the serialiser FSM stay in the top module.

Test Plan:
- Reset, then read 0x4 and 0xC → STATUS=0x02 (EMPTY), BAUD=0x000A; TXD=1, IRQ=0.
- Write BAUD=4, CTRL=1, DATA=0xA5 → TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles (40 cycles total); BUSY=1 during the frame.
- BAUD=2, write 5 bytes 0x11..0x15 back-to-back with TX_EN=0 → the 5th write gets PSLVERR=1 and OVF=1, count=4. Set TX_EN → 4 contiguous frames (80 cycles) with no idle gap. Write 0x8 to 0x4 → OVF=0.
- IRQ_EN=1, TX_EN=1, one byte at BAUD=3 → IRQ=0 while busy; IRQ=1 one cycle after STOP→IDLE.
- Byte-strobe write to CTRL with PSTRB=0000, PWDATA=3 → CTRL unchanged (0).
- Assert PRESET_n=0 during DATA bit 3 → TXD=1 immediately; after release STATUS=0x02 and no frame resumes.
